// File: rtl/seg_pkg.sv
// Shared constants, display payload and helpers for the 4-digit segment scanner.
package seg_pkg;

   localparam int unsigned NDIG = 4;
   localparam int unsigned NW   = 4;
   localparam int unsigned IW   = $clog2(NDIG);
   localparam int unsigned DW   = NDIG * NW;

   typedef enum logic {
      ST_GUARD = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   typedef struct packed {
      logic [DW-1:0]   data;
      logic [NDIG-1:0] dp;
      logic            lzb;
   } disp_t;

   // Index of the most significant non-zero nibble; 0 when all nibbles are zero.
   function automatic logic [IW-1:0] msd_idx(input logic [DW-1:0] d);
      logic [IW-1:0] m;
      m = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (d[i*NW +: NW] != '0) m = IW'(i);
      end
      return m;
   endfunction

   function automatic logic [NW-1:0] nib_sel(input logic [DW-1:0] d, input logic [IW-1:0] i);
      return d[{i, 2'b00} +: NW];
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/display bus between the scanner and its producer and downstream decoder.
interface seg_scan_ctrl_if;
   logic        LOAD;
   logic [15:0] DATA;
   logic [3:0]  DP;
   logic        LZB;
   logic [3:0]  NIB;
   logic        DPO;
   logic [3:0]  AN;
   logic        PEND;

   modport master (output LOAD, DATA, DP, LZB, input NIB, DPO, AN, PEND);
   modport slave  (input LOAD, DATA, DP, LZB, output NIB, DPO, AN, PEND);
endinterface

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Free-running digit-slot counter; pulses mark the last guard cycle and last slot cycle.
module slot_timer #(
   parameter int unsigned DIV   = 1200,
   parameter int unsigned GUARD = 60
) (
   input  logic CLK,
   input  logic RSTN,
   output logic guard_end,
   output logic slot_end
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
   end

   // Pulses are registered alongside the count so they align with the cycle they flag.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt       <= '0;
         guard_end <= (GUARD == 1);
         slot_end  <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         guard_end <= (cnt_nxt == CW'(GUARD - 1));
         slot_end  <= (cnt_nxt == CW'(DIV - 1));
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit display scanner with guard gaps, frame-aligned updates and leading-zero blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned DIV   = 1200,
   parameter int unsigned GUARD = 60
) (
   input  logic            CLK,
   input  logic            RSTN,
   seg_scan_ctrl_if.slave  bus
);

   logic          guard_end;
   logic          slot_end;
   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_nxt;
   disp_t         act;
   disp_t         act_nxt;
   disp_t         shd;
   disp_t         shd_nxt;
   disp_t         din;
   logic          pend_nxt;
   logic          boundary;
   logic          blank;

   slot_timer #(
      .DIV   (DIV),
      .GUARD (GUARD)
   ) u_timer (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .guard_end (guard_end),
      .slot_end  (slot_end)
   );

   // Next-state, register-update and blanking decisions; outputs follow the next digit.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      act_nxt   = act;
      shd_nxt   = shd;
      pend_nxt  = bus.PEND;
      din       = {bus.DATA, bus.DP, bus.LZB};
      boundary  = slot_end && (idx == IW'(NDIG - 1));

      case (state)
         ST_GUARD: if (guard_end) state_nxt = ST_SHOW;
         ST_SHOW: begin
            if (slot_end) begin
               state_nxt = ST_GUARD;
               idx_nxt   = idx + IW'(1);
            end
         end
         default: state_nxt = ST_GUARD;
      endcase

      // A load landing on the boundary bypasses the shadow so it shows this frame.
      if (bus.LOAD && boundary) begin
         act_nxt  = din;
         pend_nxt = 1'b0;
      end else begin
         if (boundary && bus.PEND) begin
            act_nxt  = shd;
            pend_nxt = 1'b0;
         end
         if (bus.LOAD) begin
            shd_nxt  = din;
            pend_nxt = 1'b1;
         end
      end

      blank = act_nxt.lzb && (idx_nxt > msd_idx(act_nxt.data));
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state    <= ST_GUARD;
         idx      <= '0;
         act      <= '0;
         shd      <= '0;
         bus.PEND <= 1'b0;
         bus.NIB  <= '0;
         bus.DPO  <= 1'b0;
         bus.AN   <= 4'b1111;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         act      <= act_nxt;
         shd      <= shd_nxt;
         bus.PEND <= pend_nxt;
         bus.NIB  <= nib_sel(act_nxt.data, idx_nxt);
         bus.DPO  <= act_nxt.dp[idx_nxt];
         bus.AN   <= (state_nxt == ST_SHOW && !blank) ? ~(4'b0001 << idx_nxt) : 4'b1111;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and random bench for seg_scan_ctrl against a cycle-indexed display model.
module tb_seg_scan_ctrl;

   localparam int DIV   = 8;
   localparam int GUARD = 2;
   localparam int FRAME = 4 * DIV;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(
      .DIV   (DIV),
      .GUARD (GUARD)
   ) dut (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   // Model: cycles since reset release, displayed word and pending word.
   int          t      = 0;
   logic [15:0] a_data = '0;
   logic [15:0] s_data = '0;
   logic [3:0]  a_dp   = '0;
   logic [3:0]  s_dp   = '0;
   logic        a_lzb  = 1'b0;
   logic        s_lzb  = 1'b0;
   logic        m_pend = 1'b0;
   logic        bnd;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         t = 0; a_data = '0; s_data = '0; a_dp = '0; s_dp = '0;
         a_lzb = 1'b0; s_lzb = 1'b0; m_pend = 1'b0;
      end else begin
         bnd = ((t % FRAME) == FRAME - 1);
         if (bus.LOAD && bnd) begin
            a_data = bus.DATA; a_dp = bus.DP; a_lzb = bus.LZB; m_pend = 1'b0;
         end else begin
            if (bnd && m_pend) begin
               a_data = s_data; a_dp = s_dp; a_lzb = s_lzb; m_pend = 1'b0;
            end
            if (bus.LOAD) begin
               s_data = bus.DATA; s_dp = bus.DP; s_lzb = bus.LZB; m_pend = 1'b1;
            end
         end
         t++;
      end
   end

   function automatic int cur_dig();
      return (t / DIV) % 4;
   endfunction

   function automatic logic [3:0] e_an();
      int msd;
      int dg;
      dg = cur_dig();
      if ((t % DIV) < GUARD) return 4'b1111;
      msd = 0;
      for (int i = 0; i < 4; i++)
         if (((a_data >> (4 * i)) & 16'h000F) != 16'h0) msd = i;
      if (a_lzb && dg > msd) return 4'b1111;
      return ~(4'b0001 << dg);
   endfunction

   function automatic logic [3:0] e_nib();
      return 4'((a_data >> (4 * cur_dig())) & 16'h000F);
   endfunction

   function automatic logic e_dpo();
      return a_dp[2'(cur_dig())];
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("an",   bus.AN,               e_an());
      chk("nib",  bus.NIB,              e_nib());
      chk("dpo",  {3'b000, bus.DPO},    {3'b000, e_dpo()});
      chk("pend", {3'b000, bus.PEND},   {3'b000, m_pend});
   endtask

   task automatic adv(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         bus.LOAD = 1'b0;
         check_all();
      end
   endtask

   task automatic adv_to(input int target);
      if (target > t) adv(target - t);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic z);
      bus.LOAD = 1'b1; bus.DATA = d; bus.DP = p; bus.LZB = z;
      adv(1);
   endtask

   logic [15:0] rd;
   int          base;

   initial begin
      bus.LOAD = 1'b0; bus.DATA = '0; bus.DP = '0; bus.LZB = 1'b0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an",   bus.AN,             4'b1111);
      chk("rst_nib",  bus.NIB,            4'h0);
      chk("rst_pend", {3'b000, bus.PEND}, 4'h0);
      rstn = 1'b1;
      check_all();

      // Reset-release timing and a mid-frame load
      adv_to(2);
      chk("an_t2", bus.AN, 4'b1110);
      adv_to(5);
      do_load(16'h1234, 4'b0100, 1'b0);
      chk("pend_set", {3'b000, bus.PEND}, 4'h1);
      adv_to(10);
      chk("an_t10", bus.AN, 4'b1101);
      adv_to(32);
      chk("pend_clr", {3'b000, bus.PEND}, 4'h0);
      chk("nib_d0", bus.NIB, 4'h4);
      adv_to(40); chk("nib_d1", bus.NIB, 4'h3);
      adv_to(48); chk("nib_d2", bus.NIB, 4'h2);
      adv_to(56); chk("nib_d3", bus.NIB, 4'h1);

      // Load exactly on the boundary cycle
      adv_to(63);
      do_load(16'hABCD, 4'b0001, 1'b0);
      chk("bnd_nib",  bus.NIB,            4'hD);
      chk("bnd_pend", {3'b000, bus.PEND}, 4'h0);
      chk("bnd_dpo",  {3'b000, bus.DPO},  4'h1);

      // Leading-zero blanking, including DP on blanked digits
      adv_to(70);
      do_load(16'h0050, 4'b1100, 1'b1);
      adv_to(99);  chk("lzb_d0", bus.AN, 4'b1110);
      adv_to(107); chk("lzb_d1", bus.AN, 4'b1101);
      adv_to(115); chk("lzb_d2", bus.AN, 4'b1111);
      adv_to(123); chk("lzb_d3", bus.AN, 4'b1111);
      do_load(16'h0000, 4'b1111, 1'b1);
      adv_to(131); chk("zero_d0", bus.AN, 4'b1110);
      adv_to(139); chk("zero_d1", bus.AN, 4'b1111);

      // Last of two loads in one frame wins
      adv_to(165);
      do_load(16'h1111, 4'b0000, 1'b0);
      adv_to(170);
      do_load(16'h2222, 4'b0000, 1'b0);
      for (int k = 0; k < 4; k++) begin
         adv_to(192 + k * DIV);
         chk("last_wins", bus.NIB, 4'h2);
      end

      // Random loads, including some on boundaries and with many leading zeros
      repeat (400) begin
         if ($urandom_range(0, 7) == 0) begin
            rd = 16'($urandom);
            rd = rd >> $urandom_range(0, 16);
            do_load(rd, 4'($urandom), 1'($urandom));
         end else begin
            adv(1);
         end
      end

      // Asynchronous reset mid-SHOW with shadow data pending
      base = t - (t % FRAME) + FRAME;
      adv_to(base + 1);
      do_load(16'h5678, 4'b1111, 1'b0);
      adv(2);
      chk("pre_rst_pend", {3'b000, bus.PEND}, 4'h1);
      #1 rstn = 1'b0;
      #1;
      chk("arst_an",   bus.AN,             4'b1111);
      chk("arst_pend", {3'b000, bus.PEND}, 4'h0);
      chk("arst_nib",  bus.NIB,            4'h0);
      @(negedge clk);
      rstn = 1'b1;
      check_all();
      adv(2 * FRAME);
      chk("post_rst_nib", bus.NIB, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
